// File: rtl/wb_multiport_master_bridge.sv
// Round-robin N-port to single Wishbone B4 classic master bridge.
// Registered bus outputs, slave-error pass-through and a bus watchdog.
module wb_multiport_master_bridge #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_i,
  input  logic [N_PORTS-1:0]          we_i,
  input  logic [N_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [N_PORTS*DATA_W-1:0]   wdata_i,
  input  logic [N_PORTS*SEL_W-1:0]    be_i,
  output logic [N_PORTS-1:0]          ready_o,
  output logic [N_PORTS-1:0]          err_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [ADDR_W-1:0]           wb_adr_o,
  output logic [DATA_W-1:0]           wb_dat_o,
  output logic [SEL_W-1:0]            wb_sel_o,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i,
  input  logic [DATA_W-1:0]           wb_dat_i
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t state, state_nx;

  // Flat port buses viewed as packed per-port arrays (same bit layout).
  logic [N_PORTS-1:0][ADDR_W-1:0] addr_a;
  logic [N_PORTS-1:0][DATA_W-1:0] wdata_a;
  logic [N_PORTS-1:0][SEL_W-1:0]  be_a;

  assign addr_a  = addr_i;
  assign wdata_a = wdata_i;
  assign be_a    = be_i;

  logic [PW-1:0]      rr_ptr, grant, pick, rr_nx;
  logic               pick_vld;
  logic [CW-1:0]      cnt;
  logic               timeout_hit;
  logic [N_PORTS-1:0] grant_oh;

  // Walk from the farthest offset down so the port closest to rr_ptr wins.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (req_i[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign rr_nx       = (pick == PW'(N_PORTS - 1)) ? '0 : pick + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign grant_oh    = N_PORTS'(1) << grant;
  assign wb_stb_o    = wb_cyc_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = BUS;
      BUS:     if (wb_err_i || wb_ack_i || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant    <= '0;
      cnt      <= '0;
      ready_o  <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= '0;
          err_o   <= '0;
          cnt     <= '0;
          if (pick_vld) begin
            grant    <= pick;
            rr_ptr   <= rr_nx;
            wb_cyc_o <= 1'b1;
            wb_we_o  <= we_i[pick];
            wb_adr_o <= addr_a[pick];
            wb_dat_o <= wdata_a[pick];
            wb_sel_o <= be_a[pick];
          end
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          // Slave error beats ack; a real ack beats the watchdog.
          if (wb_err_i) begin
            wb_cyc_o <= 1'b0;
            err_o    <= grant_oh;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            ready_o  <= grant_oh;
            if (!wb_we_o) rdata_o <= wb_dat_i;
          end else if (timeout_hit) begin
            wb_cyc_o <= 1'b0;
            err_o    <= grant_oh;
          end
        end
        default: begin
          ready_o <= '0;
          err_o   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_multiport_master_bridge.sv
// Scoreboard bench: address bits steer the slave model (response kind, latency),
// so every expected outcome follows from the request alone.
module tb_wb_multiport_master_bridge;

  localparam int NP = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_i, we_i;
  logic [63:0]   addr_i, wdata_i;
  logic [7:0]    be_i;
  logic [1:0]    ready_o, err_o;
  logic [31:0]   rdata_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]   wb_adr_o, wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i, wb_err_i;
  logic [31:0]   wb_dat_i;

  wb_multiport_master_bridge #(.N_PORTS(NP), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .be_i(be_i), .ready_o(ready_o), .err_o(err_o), .rdata_o(rdata_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct { int p; int t; } log_t;

  txn_t        exp_q[2][$];
  log_t        log_q[$];
  int          vectors = 0, miscompares = 0;
  int          cyc_no = 0, t_start = 0;
  logic [31:0] model_rdata = '0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;
  int          bus_len = 0;

  // Slave read data is a fixed function of the address.
  function automatic logic [31:0] dfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
  endfunction

  assign wb_dat_i = wb_cyc_o ? dfn(wb_adr_o) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  // Slave: addr[5:4] = 0 ack, 1 err, 2 ack+err, 3 silent; addr[2:0] = wait cycles.
  // Outside a cycle it drives random ack/err noise that must be ignored.
  initial begin
    int scnt;
    scnt = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o) begin
        chk("stb_eq_cyc", wb_stb_o, 1'b1);
        if (scnt == 0) begin
          cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_sel = wb_sel_o; cap_we = wb_we_o;
          bus_len = 1;
        end else begin
          bus_len++;
          chk("bus_stable", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o}, {cap_adr, cap_dat, cap_sel, cap_we});
        end
        wb_ack_i = (scnt == int'(wb_adr_o[2:0])) && (wb_adr_o[5:4] == 2'd0 || wb_adr_o[5:4] == 2'd2);
        wb_err_i = (scnt == int'(wb_adr_o[2:0])) && (wb_adr_o[5:4] == 2'd1 || wb_adr_o[5:4] == 2'd2);
        scnt++;
      end else begin
        scnt = 0;
        wb_ack_i = 1'($urandom_range(0, 1));
        wb_err_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the port's expected transaction on every response pulse.
  initial begin
    logic [1:0] pls;
    int         p, exp_len;
    logic       exp_ok;
    txn_t       e;
    forever begin
      @(negedge clk);
      pls = ready_o | err_o;
      if (!rst && pls != 2'b00) begin
        p = pls[1] ? 1 : 0;
        log_q.push_back('{p, cyc_no});
        vectors++;
        if (!$onehot({ready_o, err_o})) begin
          miscompares++;
          $display("FAIL onehot: got ready=%b err=%b expected a single bit", ready_o, err_o);
        end else if (exp_q[p].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: got pulse on port %0d expected none", p);
        end else begin
          e       = exp_q[p].pop_front();
          exp_ok  = (e.addr[5:4] == 2'd0);
          exp_len = (e.addr[5:4] == 2'd3) ? TO : int'(e.addr[2:0]) + 1;
          if (exp_ok && !e.we) model_rdata = dfn(e.addr);
          chk("resp_kind", {ready_o[p], err_o[p]}, {exp_ok, !exp_ok});
          chk("rdata", rdata_o, model_rdata);
          chk("bus_adr_we", {cap_adr, cap_we}, {e.addr, e.we});
          if (e.we) chk("bus_dat_sel", {cap_dat, cap_sel}, {e.wdata, e.be});
          chk("cyc_len", bus_len, exp_len);
        end
      end
    end
  end

  task automatic issue(input int p, input bit fixed);
    txn_t t;
    int   r;
    t.addr  = $urandom;
    t.we    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.be    = 4'($urandom_range(0, 15));
    if (fixed) t.addr[5:0] = 6'd0;
    else begin
      r = $urandom_range(0, 9);
      t.addr[5:4] = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
    end
    req_i[p]             = 1'b1;
    we_i[p]              = t.we;
    addr_i[p*32 +: 32]   = t.addr;
    wdata_i[p*32 +: 32]  = t.wdata;
    be_i[p*4 +: 4]       = t.be;
    exp_q[p].push_back(t);
  endtask

  // Each port holds its request until its own pulse, then idles 0..3 cycles.
  task automatic run_traffic(input int n0, input int n1, input bit fixed);
    int left[2], gap[2], budget;
    bit busy[2];
    left[0] = n0; left[1] = n1; gap[0] = 0; gap[1] = 0; busy[0] = 0; busy[1] = 0;
    budget = 0;
    while ((left[0] + left[1] > 0 || busy[0] || busy[1]) && budget < 6000) begin
      @(negedge clk);
      if (budget == 0) t_start = cyc_no;
      budget++;
      for (int p = 0; p < NP; p++) begin
        if (busy[p] && (ready_o[p] || err_o[p])) begin
          busy[p]  = 0;
          req_i[p] = 1'b0;
          gap[p]   = fixed ? 0 : $urandom_range(0, 3);
        end
        if (!busy[p] && left[p] > 0) begin
          if (gap[p] == 0) begin
            issue(p, fixed);
            left[p]--;
            busy[p] = 1;
          end else gap[p]--;
        end
      end
    end
    if (budget >= 6000) begin
      miscompares++;
      $display("FAIL traffic_timeout: got no completion after %0d cycles expected all done", budget);
    end
    @(negedge clk);
    chk("queues_drained", {32'(exp_q[0].size()), 32'(exp_q[1].size())}, 64'd0);
  endtask

  initial begin
    int waitc;
    rst = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {ready_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 64'd0);
    chk("reset_data", {rdata_o, wb_adr_o}, 64'd0);
    chk("reset_wdat", wb_dat_o, 64'd0);
    rst = 1'b0;

    // Both ports saturating with a zero-wait slave: strict alternation, 3 cycles apiece.
    log_q.delete();
    run_traffic(4, 4, 1'b1);
    chk("b2b_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      chk("first_latency", log_q[0].t - t_start, 2);
      for (int i = 0; i < 8; i++) chk("rr_order", log_q[i].p, i % 2);
      for (int i = 1; i < 8; i++) chk("b2b_spacing", log_q[i].t - log_q[i-1].t, 3);
    end

    run_traffic(60, 60, 1'b0);

    // Reset in the middle of a silent-slave write: outputs clear at once, no pulse.
    @(negedge clk);
    issue(0, 1'b1);
    addr_i[31:0] = 32'h0000_1030;
    we_i[0]      = 1'b1;
    void'(exp_q[0].pop_back());
    waitc = 0;
    while (!wb_cyc_o && waitc < 5) begin
      @(negedge clk);
      waitc++;
    end
    chk("rst_mid_cyc_seen", wb_cyc_o, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid_outs", {wb_cyc_o, wb_stb_o, wb_we_o, ready_o, err_o, wb_adr_o}, 64'd0);
    req_i = '0;
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    run_traffic(0, 1, 1'b1);
    chk("post_rst_port1", log_q.size() == 1 ? log_q[0].p : -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
